approx_add_pipe: RTL and testbench

- Parametrised, pipelined successor of the 12-bit unsigned ripple-carry adder family.
- W-bit unsigned adder with a runtime-selectable lower-part-OR approximation on the K least significant bits.
- Carry chain is split into STAGES registered segments, with a valid/ready stream interface.
- A built-in saturating counter records how many results differed from the exact sum; the characterisation benches use it for error-probability (EP) measurement.

---
 rtl/approx_add_pipe.sv | 161 ++++++++++++++++
 tb/tb_approx_add_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_pipe.sv
// Pipelined W-bit unsigned adder with a runtime-selectable lower-part-OR
// approximation on the K least significant bits. The carry chain is cut
// into STAGES registered segments behind a valid/ready stream interface.
// An exact sum travels alongside the approximate one so each result can
// be flagged as mismatching. A saturating counter tallies delivered
// mismatches.
module approx_add_pipe #(
  parameter int W      = 12,
  parameter int K      = 2,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_sum,
  output logic             out_mode,
  output logic             out_mismatch,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int SEG = W / STAGES;

  // Each stage carries two W-bit words. In the approximate word, bits below
  // the segments already processed hold approximate sum bits and bits above
  // still hold operand A. The exact word is laid out the same way, holding
  // exact sum bits below and operand B above. Every stage consumes one
  // SEG-wide slice of both operands and overwrites it with sum bits, so no
  // separate operand delay lines are needed.
  logic [W-1:0]      apx_r [STAGES];
  logic [W-1:0]      ext_r [STAGES];
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] md_r;
  logic [STAGES-1:0] cy_apx_r;
  logic [STAGES-1:0] cy_ext_r;

  logic [W-1:0]      apx_src [STAGES];
  logic [W-1:0]      ext_src [STAGES];
  logic [STAGES-1:0] vld_src;
  logic [STAGES-1:0] md_src;
  logic [STAGES-1:0] cy_apx_src;
  logic [STAGES-1:0] cy_ext_src;

  logic [W-1:0]      apx_nxt [STAGES];
  logic [W-1:0]      ext_nxt [STAGES];
  logic [STAGES-1:0] cy_apx_nxt;
  logic [STAGES-1:0] cy_ext_nxt;

  logic              advance;
  logic [W:0]        exact_sum;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Stage inputs: stage 0 takes the new beat, later stages take the
  // registers of the stage before them.
  always_comb begin
    apx_src[0]    = in_a;
    ext_src[0]    = in_b;
    vld_src[0]    = in_valid;
    md_src[0]     = in_mode;
    cy_apx_src[0] = 1'b0;
    cy_ext_src[0] = 1'b0;
    for (int unsigned s = 1; s < STAGES; s++) begin
      apx_src[s]    = apx_r[s-1];
      ext_src[s]    = ext_r[s-1];
      vld_src[s]    = vld_r[s-1];
      md_src[s]     = md_r[s-1];
      cy_apx_src[s] = cy_apx_r[s-1];
      cy_ext_src[s] = cy_ext_r[s-1];
    end
  end

  // Per-stage slice adders: approximate and exact ripple chains side by side.
  // Approximated bits OR the operands and kill the carry, except that the
  // topmost approximated bit forwards a[K-1] & b[K-1] into bit K.
  always_comb begin
    logic        ca;
    logic        ce;
    logic        ai;
    logic        bi;
    int unsigned i;
    ca = 1'b0;
    ce = 1'b0;
    ai = 1'b0;
    bi = 1'b0;
    i  = 0;
    cy_apx_nxt = '0;
    cy_ext_nxt = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      apx_nxt[s] = apx_src[s];
      ext_nxt[s] = ext_src[s];
      ca = cy_apx_src[s];
      ce = cy_ext_src[s];
      for (int unsigned j = 0; j < SEG; j++) begin
        i  = s * SEG + j;
        ai = apx_src[s][i];
        bi = ext_src[s][i];
        if (md_src[s] && (i < K)) begin
          apx_nxt[s][i] = ai | bi;
          ca = (i == K - 1) ? (ai & bi) : 1'b0;
        end else begin
          apx_nxt[s][i] = ai ^ bi ^ ca;
          ca = (ai & bi) | (ca & (ai ^ bi));
        end
        ext_nxt[s][i] = ai ^ bi ^ ce;
        ce = (ai & bi) | (ce & (ai ^ bi));
      end
      cy_apx_nxt[s] = ca;
      cy_ext_nxt[s] = ce;
    end
  end

  // Pipeline registers: all stages shift together on advance, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r    <= '0;
      md_r     <= '0;
      cy_apx_r <= '0;
      cy_ext_r <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        apx_r[s] <= '0;
        ext_r[s] <= '0;
      end
    end else if (advance) begin
      vld_r    <= vld_src;
      md_r     <= md_src;
      cy_apx_r <= cy_apx_nxt;
      cy_ext_r <= cy_ext_nxt;
      for (int unsigned s = 0; s < STAGES; s++) begin
        apx_r[s] <= apx_nxt[s];
        ext_r[s] <= ext_nxt[s];
      end
    end
  end

  assign exact_sum    = {cy_ext_r[STAGES-1], ext_r[STAGES-1]};
  assign out_valid    = vld_r[STAGES-1];
  assign out_mode     = md_r[STAGES-1];
  assign out_sum      = {cy_apx_r[STAGES-1], apx_r[STAGES-1]};
  assign out_mismatch = out_valid & (out_sum != exact_sum);

  // Mismatch counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench for approx_add_pipe: directed vector table, reset and
// mid-flight reset sequences, randomized backpressure stream, counter
// saturation/clear on a narrow-counter instance, and a parameter sweep with
// error-probability measurement.
module tb_approx_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- main instance (12,2,3,16) ----------------
  logic        rst_n;
  logic        in_valid, in_ready, in_mode;
  logic [11:0] in_a, in_b;
  logic        out_valid, out_ready, out_mode, out_mismatch;
  logic [12:0] out_sum;
  logic [15:0] err_cnt;
  logic        err_clr;

  approx_add_pipe #(.W(12), .K(2), .STAGES(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_mode(out_mode),
    .out_mismatch(out_mismatch), .err_cnt(err_cnt), .err_clr(err_clr));

  // ---------------- narrow counter instance (CNT_W=4) ----------------
  logic        sat_valid, sat_rdy, sat_ovalid, sat_omode, sat_mis, sat_clr;
  logic [11:0] sat_a, sat_b;
  logic [12:0] sat_sum;
  logic [3:0]  sat_cnt;

  approx_add_pipe #(.W(12), .K(2), .STAGES(3), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(sat_valid), .in_ready(sat_rdy),
    .in_a(sat_a), .in_b(sat_b), .in_mode(1'b1), .out_valid(sat_ovalid),
    .out_ready(1'b1), .out_sum(sat_sum), .out_mode(sat_omode),
    .out_mismatch(sat_mis), .err_cnt(sat_cnt), .err_clr(sat_clr));

  // ---------------- sweep instances ----------------
  logic        sw_valid, sw_clr;
  logic        sw_mode [3];
  logic        p_rdy [3];
  logic        p_ovalid [3];
  logic        p_omode [3];
  logic        p_mis [3];
  logic [7:0]  p1_a, p1_b;
  logic [15:0] p2_a, p2_b;
  logic [11:0] p3_a, p3_b;
  logic [8:0]  p1_sum;
  logic [16:0] p2_sum;
  logic [12:0] p3_sum;
  logic [15:0] p1_cnt, p2_cnt, p3_cnt;

  approx_add_pipe #(.W(8), .K(0), .STAGES(1), .CNT_W(16)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(p_rdy[0]),
    .in_a(p1_a), .in_b(p1_b), .in_mode(sw_mode[0]), .out_valid(p_ovalid[0]),
    .out_ready(1'b1), .out_sum(p1_sum), .out_mode(p_omode[0]),
    .out_mismatch(p_mis[0]), .err_cnt(p1_cnt), .err_clr(sw_clr));

  approx_add_pipe #(.W(16), .K(4), .STAGES(4), .CNT_W(16)) u_p2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(p_rdy[1]),
    .in_a(p2_a), .in_b(p2_b), .in_mode(sw_mode[1]), .out_valid(p_ovalid[1]),
    .out_ready(1'b1), .out_sum(p2_sum), .out_mode(p_omode[1]),
    .out_mismatch(p_mis[1]), .err_cnt(p2_cnt), .err_clr(sw_clr));

  approx_add_pipe #(.W(12), .K(11), .STAGES(2), .CNT_W(16)) u_p3 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(p_rdy[2]),
    .in_a(p3_a), .in_b(p3_b), .in_mode(sw_mode[2]), .out_valid(p_ovalid[2]),
    .out_ready(1'b1), .out_sum(p3_sum), .out_mode(p_omode[2]),
    .out_mismatch(p_mis[2]), .err_cnt(p3_cnt), .err_clr(sw_clr));

  // ---------------- reference model ----------------
  // Low k bits are a|b, carry into bit k is a[k-1]&b[k-1], upper part is a
  // plain add of the shifted operands.
  function automatic int unsigned model(int unsigned a, int unsigned b, bit mode, int k);
    int unsigned lo, c, hi;
    if (!mode || k == 0) return a + b;
    lo = (a | b) & ((32'd1 << k) - 1);
    c  = (a >> (k - 1)) & (b >> (k - 1)) & 1;
    hi = (a >> k) + (b >> k) + c;
    return (hi << k) | lo;
  endfunction

  function automatic int unsigned pack(int unsigned sum, bit mis, bit mode);
    return sum | (int'(mis) << 20) | (int'(mode) << 21);
  endfunction

  task automatic check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        mode;
    logic [12:0] sum;
    logic        mis;
  } vec_t;

  vec_t tbl [12];
  int   exp_err = 0;

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    in_a = v.a; in_b = v.b; in_mode = v.mode; in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      in_valid = 1'b0;
    end while (!out_valid && n < 10);
    check($sformatf("vec%0d_latency", idx), n, 3);
    check($sformatf("vec%0d_sum", idx), out_sum, v.sum);
    check($sformatf("vec%0d_mismatch", idx), out_mismatch, v.mis);
    check($sformatf("vec%0d_mode", idx), out_mode, v.mode);
    if (v.mis) exp_err++;
    tick();
    check($sformatf("vec%0d_err_cnt", idx), err_cnt, exp_err);
  endtask

  // ---------------- sweep helpers ----------------
  int unsigned q_sw [3][$];
  int          sw_bad [3];
  int          mm [3];
  int          k_of [3];

  task automatic sweep_cycle(input bit drive, input bit approx, input int idx);
    int unsigned act [3];
    int unsigned a [3];
    int unsigned b [3];
    int unsigned e;
    int unsigned s;
    act[0] = pack(p1_sum, p_mis[0], p_omode[0]);
    act[1] = pack(p2_sum, p_mis[1], p_omode[1]);
    act[2] = pack(p3_sum, p_mis[2], p_omode[2]);
    for (int i = 0; i < 3; i++) begin
      if (p_ovalid[i]) begin
        if (q_sw[i].size() == 0) sw_bad[i]++;
        else begin
          e = q_sw[i].pop_front();
          if (e != act[i]) sw_bad[i]++;
        end
      end
    end
    if (drive) begin
      sw_valid = 1'b1;
      a[0] = $urandom & 32'hFF;    b[0] = $urandom & 32'hFF;
      a[1] = $urandom & 32'hFFFF;  b[1] = $urandom & 32'hFFFF;
      a[2] = $urandom & 32'hFFF;   b[2] = $urandom & 32'hFFF;
      if (approx) begin
        // walk every low-nibble pair so the K=4 EP sample is balanced
        a[1] = (a[1] & 32'hFFF0) | (idx & 15);
        b[1] = (b[1] & 32'hFFF0) | ((idx >> 4) & 15);
      end
      p1_a = 8'(a[0]);  p1_b = 8'(b[0]);
      p2_a = 16'(a[1]); p2_b = 16'(b[1]);
      p3_a = 12'(a[2]); p3_b = 12'(b[2]);
      for (int i = 0; i < 3; i++) begin
        sw_mode[i] = approx ? 1'b1 : 1'($urandom_range(0, 1));
        s = model(a[i], b[i], sw_mode[i], k_of[i]);
        q_sw[i].push_back(pack(s, s != a[i] + b[i], sw_mode[i]));
        if (approx && s != a[i] + b[i]) mm[i]++;
      end
      #1;
      for (int i = 0; i < 3; i++) if (!p_rdy[i]) sw_bad[i]++;
    end else begin
      sw_valid = 1'b0;
    end
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, seen, sent, got, bp_bad;
    int unsigned q_bp [$];
    int unsigned ea, eb, es, e;
    bit em;
    bit prev_stall;
    int unsigned prev_out;
    real ep, ep_req;
    int sn;

    tbl[0]  = '{12'hFFF, 12'h001, 1'b0, 13'h1000, 1'b0};
    tbl[1]  = '{12'h800, 12'h800, 1'b0, 13'h1000, 1'b0};
    tbl[2]  = '{12'h003, 12'h001, 1'b1, 13'h0003, 1'b1};
    // bit1 = 1|1, carry a1&b1 lands in bit2 -> 0x006 against exact 0x004
    tbl[3]  = '{12'h002, 12'h002, 1'b1, 13'h0006, 1'b1};
    tbl[4]  = '{12'hFFF, 12'hFFF, 1'b0, 13'h1FFE, 1'b0};
    tbl[5]  = '{12'hFFF, 12'hFFF, 1'b1, 13'h1FFF, 1'b1};
    tbl[6]  = '{12'h001, 12'h002, 1'b1, 13'h0003, 1'b0};
    tbl[7]  = '{12'h7F4, 12'h00B, 1'b1, 13'h07FF, 1'b0};
    tbl[8]  = '{12'h555, 12'hAAA, 1'b1, 13'h0FFF, 1'b0};
    tbl[9]  = '{12'h0FF, 12'h001, 1'b1, 13'h00FF, 1'b1};
    tbl[10] = '{12'hFFF, 12'h001, 1'b1, 13'h0FFF, 1'b1};
    tbl[11] = '{12'h000, 12'h000, 1'b1, 13'h0000, 1'b0};
    k_of[0] = 0; k_of[1] = 4; k_of[2] = 11;
    for (int i = 0; i < 3; i++) begin sw_bad[i] = 0; mm[i] = 0; sw_mode[i] = 1'b0; end

    rst_n = 1'b0; in_valid = 1'b1; in_a = 12'h123; in_b = 12'h456; in_mode = 1'b0;
    out_ready = 1'b1; err_clr = 1'b0;
    sat_valid = 1'b0; sat_a = '0; sat_b = '0; sat_clr = 1'b0;
    sw_valid = 1'b0; sw_clr = 1'b0;
    p1_a = '0; p1_b = '0; p2_a = '0; p2_b = '0; p3_a = '0; p3_b = '0;

    // reset held for two cycles with in_valid high
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_mismatch", out_mismatch, 0);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      in_valid = 1'b0;
    end while (!out_valid && n < 10);
    check("post_rst_latency", n, 3);
    check("post_rst_sum", out_sum, 13'h579);
    tick();

    // directed table
    foreach (tbl[i]) run_vec(tbl[i], i);

    // reset while beats are in flight: nothing must come out afterwards
    in_a = 12'h00F; in_b = 12'h00F; in_mode = 1'b1; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_err_cnt", err_cnt, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin tick(); if (out_valid) seen++; end
    check("midrst_no_emit", seen, 0);
    exp_err = 0;

    // randomized stream under out_ready pattern 1,0,0
    sent = 0; got = 0; bp_bad = 0; prev_stall = 1'b0; prev_out = 0;
    for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
      if (prev_stall && (!out_valid || pack(out_sum, out_mismatch, out_mode) != prev_out))
        bp_bad++;
      out_ready = (cyc % 3 == 0);
      if (sent < 40) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = 12'($urandom); in_b = 12'($urandom); in_mode = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_ready !== (out_ready || !out_valid)) bp_bad++;
      if (in_valid && in_ready) begin
        ea = in_a; eb = in_b; em = in_mode;
        es = model(ea, eb, em, 2);
        q_bp.push_back(pack(es, es != ea + eb, em));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q_bp.size() == 0) bp_bad++;
        else begin
          e = q_bp.pop_front();
          if (e != pack(out_sum, out_mismatch, out_mode)) bp_bad++;
          if (e[20]) exp_err++;
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = pack(out_sum, out_mismatch, out_mode);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_errors", bp_bad, 0);
    check("bp_sent", sent, 40);
    check("bp_received", got, 40);
    check("bp_leftover", q_bp.size(), 0);
    check("bp_err_cnt", err_cnt, exp_err);

    // narrow counter saturation, then clear racing an increment
    sat_a = 12'h003; sat_b = 12'h001; sat_valid = 1'b1;
    repeat (20) tick();
    sat_valid = 1'b0;
    repeat (5) tick();
    check("sat_cnt_15", sat_cnt, 15);
    for (int r = 0; r < 2; r++) begin
      sat_valid = 1'b1;
      sn = 0;
      do begin tick(); sn++; sat_valid = 1'b0; end while (!sat_ovalid && sn < 10);
      check($sformatf("sat_latency%0d", r), sn, 3);
      check($sformatf("sat_sum%0d", r), sat_sum, 13'h003);
      check($sformatf("sat_mis%0d", r), sat_mis, 1);
      sat_clr = (r == 0);
      tick();
      sat_clr = 1'b0;
      check($sformatf("sat_after%0d", r), sat_cnt, r);
    end

    // parameter sweep: mixed modes, then all-approximate for EP
    for (int i = 0; i < 2000; i++) sweep_cycle(1'b1, 1'b0, i);
    repeat (6) sweep_cycle(1'b0, 1'b0, 0);
    sw_clr = 1'b1; tick(); sw_clr = 1'b0;
    for (int i = 0; i < 10240; i++) sweep_cycle(1'b1, 1'b1, i);
    repeat (6) sweep_cycle(1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sweep%0d_miscompares", i), sw_bad[i], 0);
      check($sformatf("sweep%0d_leftover", i), q_sw[i].size(), 0);
    end
    check("sweep0_err_cnt", p1_cnt, mm[0]);
    check("sweep1_err_cnt", p2_cnt, mm[1]);
    check("sweep2_err_cnt", p3_cnt, mm[2]);
    for (int i = 0; i < 3; i++) begin
      ep = (i == 0) ? real'(p1_cnt) : (i == 1) ? real'(p2_cnt) : real'(p3_cnt);
      ep = ep / 10240.0;
      ep_req = 1.0 - (0.75 ** k_of[i]);
      n_cmp++;
      if (ep - ep_req > 0.01 || ep_req - ep > 0.01) begin
        n_bad++;
        $display("FAIL sweep%0d_ep: measured %f, analytic %f", i, ep, ep_req);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // hard stop in case a wait above never resolves
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
